// File: rtl/io_panel_pkg.sv
// Shared constants for the front-panel I/O controller: the seven-segment
// decode table, the blank pattern and the decimal-point bit position.
package io_panel_pkg;

   // Segment pattern with every segment and the dp off (active-low).
   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam int         SEG_DP_BIT = 7;

   // Active-low {dp, g..a} patterns for hex digits, entry n decodes nibble n.
   localparam logic [15:0][7:0] HEX_SEG = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      return HEX_SEG[nib];
   endfunction

endpackage

// File: rtl/io_debounce.sv
// Single-button debouncer: two-flop synchroniser followed by a stability
// counter. The debounced level only moves after the synchronised input has
// disagreed with it on DB_CYCLES+1 consecutive samples; any bounce restarts
// the count.
module io_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int            CW     = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_TC = CW'(DB_CYCLES);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Count consecutive disagreeing samples and accept the new level at the top.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync2 == level) begin
         cnt <= '0;
      end else if (cnt == CNT_TC) begin
         level <= sync2;
         cnt   <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/io_panel.sv
// Front-panel I/O controller: debounced buttons, press-event interrupt
// pending bits with mask and write-1-to-clear ack, and a multiplexed
// seven-segment display showing one of two pages of a memory word.
// Optional feature macro: IO_PANEL_ZERO_BLANK_EN (leading-zero blanking).
module io_panel
   import io_panel_pkg::*;
#(
   parameter int NUM_BTN    = 2,
   parameter int NUM_DIGITS = 4,
   parameter int DB_CYCLES  = 1_000_000,
   parameter int SCAN_DIV   = 50_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_BTN-1:0]        btn_raw,
   output logic [NUM_BTN-1:0]        btn_level,
   input  logic [NUM_BTN-1:0]        irq_mask,
   input  logic [NUM_BTN-1:0]        irq_ack,
   output logic [NUM_BTN-1:0]        irq_pending,
   output logic                      irq,
   input  logic [8*NUM_DIGITS-1:0]   disp_data,
   input  logic                      disp_page,
   input  logic                      disp_en,
   output logic [NUM_DIGITS-1:0]     an,
   output logic [7:0]                seg
);

   localparam int                    DW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int                    PW       = $clog2(SCAN_DIV);
   localparam logic [PW-1:0]         PRE_TC   = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0]         DIG_LAST = DW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = '1;

   logic [NUM_BTN-1:0]      level_d;
   logic [NUM_BTN-1:0]      pending;
   logic [PW-1:0]           pre_cnt;
   logic [DW-1:0]           digit_idx;
   logic                    en_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic [7:0]              seg_q;

   logic [4*NUM_DIGITS-1:0] page_word;
   logic [3:0]              cur_nib;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   an_next;
   logic [7:0]              seg_next;
`ifdef IO_PANEL_ZERO_BLANK_EN
   logic [DW-1:0]           msd_idx;
`endif

   // One debouncer per button.
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
      io_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[i]),
         .level (btn_level[i])
      );
   end

   // Press events latch into pending; a new press wins over a same-cycle ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_d <= '0;
         pending <= '0;
      end else begin
         level_d <= btn_level;
         pending <= (pending & ~irq_ack) | (btn_level & ~level_d);
      end
   end

   assign irq_pending = pending;
   assign irq         = |(pending & irq_mask);

   // Slot prescaler and digit index; the index advances on prescaler terminal count.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt   <= '0;
         digit_idx <= '0;
      end else if (pre_cnt == PRE_TC) begin
         pre_cnt   <= '0;
         digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + DW'(1);
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   // Select the active digit's nibble from the chosen page and decode it.
   always_comb begin
      page_word = disp_page ? disp_data[8*NUM_DIGITS-1:4*NUM_DIGITS]
                            : disp_data[4*NUM_DIGITS-1:0];
      cur_nib   = 4'h0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (digit_idx == DW'(d)) begin
            cur_nib = page_word[4*d +: 4];
         end
      end
`ifdef IO_PANEL_ZERO_BLANK_EN
      // Digit 0 is never blanked since msd_idx bottoms out at 0.
      msd_idx = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (page_word[4*d +: 4] != 4'h0) begin
            msd_idx = DW'(d);
         end
      end
      cur_blank = (digit_idx > msd_idx);
`else
      cur_blank = 1'b0;
`endif
      an_next  = ~(AN_ONE << digit_idx);
      seg_next = hex_to_seg(cur_nib);
      if (disp_page && (digit_idx == '0)) begin
         seg_next[SEG_DP_BIT] = 1'b0;
      end
      if (cur_blank) begin
         an_next  = AN_OFF;
         seg_next = SEG_BLANK;
      end
   end

   // Register the display drive and the enable so both outputs move together.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q  <= 1'b0;
         an_q  <= AN_OFF;
         seg_q <= SEG_BLANK;
      end else begin
         en_q  <= disp_en;
         an_q  <= an_next;
         seg_q <= seg_next;
      end
   end

   // Blanking gates registered values only, so scanning keeps running underneath.
   assign an  = en_q ? an_q  : AN_OFF;
   assign seg = en_q ? seg_q : SEG_BLANK;

endmodule

// File: tb/tb_io_panel.sv
// Self-checking bench for io_panel with NUM_BTN=2, NUM_DIGITS=4,
// DB_CYCLES=4, SCAN_DIV=3. Honours IO_PANEL_ZERO_BLANK_EN when defined.
module tb_io_panel;

   localparam int NB = 2;
   localparam int ND = 4;
   localparam int DB = 4;
   localparam int SD = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] irq_mask;
   logic [NB-1:0] irq_ack;
   logic [NB-1:0] irq_pending;
   logic          irq;
   logic [31:0]   disp_data;
   logic          disp_page;
   logic          disp_en;
   logic [ND-1:0] an;
   logic [7:0]    seg;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   io_panel #(
      .NUM_BTN    (NB),
      .NUM_DIGITS (ND),
      .DB_CYCLES  (DB),
      .SCAN_DIV   (SD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .irq_mask    (irq_mask),
      .irq_ack     (irq_ack),
      .irq_pending (irq_pending),
      .irq         (irq),
      .disp_data   (disp_data),
      .disp_page   (disp_page),
      .disp_en     (disp_en),
      .an          (an),
      .seg         (seg)
   );

   // Reference model state
   logic [7:0]    hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   int            m_cyc;
   int            m_run [NB];
   logic [NB-1:0] m_sp1, m_sp2, m_lvl, m_lvl_prev, m_pend;
   logic [ND-1:0] m_an;
   logic [7:0]    m_seg;

   // Advance one clock: sample inputs, update the model across the edge,
   // and return at the falling edge where outputs are checked.
   task automatic step();
      logic          r, pg, en, blank;
      logic [NB-1:0] raw, ack;
      logic [31:0]   data;
      logic [15:0]   pw;
      logic [3:0]    nib;
      int            idx, msd;
      r = rst; raw = btn_raw; ack = irq_ack; data = disp_data; pg = disp_page; en = disp_en;
      @(posedge clk);
      if (r) begin
         m_cyc = 0; m_sp1 = '0; m_sp2 = '0; m_lvl = '0; m_lvl_prev = '0; m_pend = '0;
         for (int i = 0; i < NB; i++) m_run[i] = 0;
         m_an = '1; m_seg = 8'hFF;
      end else begin
         idx   = (m_cyc / SD) % ND;
         pw    = pg ? data[31:16] : data[15:0];
         nib   = pw[4*idx +: 4];
         blank = 1'b0;
         msd   = 0;
`ifdef IO_PANEL_ZERO_BLANK_EN
         for (int d = 0; d < ND; d++) if (pw[4*d +: 4] != 4'h0) msd = d;
         blank = (idx > msd);
`endif
         if (en && !blank) begin
            m_an  = ~(4'b0001 << idx);
            m_seg = hex_tab[nib];
            if (idx == 0 && pg) m_seg[7] = 1'b0;
         end else begin
            m_an  = '1;
            m_seg = 8'hFF;
         end
         m_cyc++;
         m_pend     = (m_pend & ~ack) | (m_lvl & ~m_lvl_prev);
         m_lvl_prev = m_lvl;
         for (int i = 0; i < NB; i++) begin
            if (m_sp2[i] == m_lvl[i]) m_run[i] = 0;
            else begin
               m_run[i]++;
               if (m_run[i] == DB + 1) begin
                  m_lvl[i] = m_sp2[i];
                  m_run[i] = 0;
               end
            end
         end
         m_sp2 = m_sp1;
         m_sp1 = raw;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_raw = '0; irq_mask = '0; irq_ack = '0;
      disp_data = '0; disp_page = 1'b0; disp_en = 1'b0;
      repeat (3) step();
      n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got=%b exp=1111", an); end
      n_tests++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg got=%h exp=ff", seg); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
      n_tests++; if (btn_level !== 2'b00) begin n_fail++; $display("FAIL reset_level got=%b exp=00", btn_level); end
      n_tests++; if (irq_pending !== 2'b00) begin n_fail++; $display("FAIL reset_pending got=%b exp=00", irq_pending); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_debounce();
      logic el, ep;
      btn_raw[0] = 1'b1;
      repeat (3) step();
      btn_raw[0] = 1'b0;
      repeat (10) step();
      n_tests++; if (btn_level !== 2'b00) begin n_fail++; $display("FAIL glitch_level got=%b exp=00", btn_level); end
      n_tests++; if (irq_pending !== 2'b00) begin n_fail++; $display("FAIL glitch_pending got=%b exp=00", irq_pending); end
      btn_raw[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         el = (k >= 6);
         ep = (k >= 7);
         n_tests++; if (btn_level[0] !== el) begin n_fail++; $display("FAIL db_level edge=%0d got=%b exp=%b", k, btn_level[0], el); end
         n_tests++; if (irq_pending[0] !== ep) begin n_fail++; $display("FAIL db_pending edge=%0d got=%b exp=%b", k, irq_pending[0], ep); end
      end
      irq_mask = 2'b01;
      #1;
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL db_irq got=%b exp=1", irq); end
   endtask

   task automatic test_ack_collision();
      int t;
      btn_raw[1] = 1'b1;
      t = 0; while (btn_level[1] !== 1'b1 && t < 20) begin step(); t++; end
      n_tests++; if (btn_level[1] !== 1'b1) begin n_fail++; $display("FAIL wait_level1 got=%b exp=1", btn_level[1]); end
      irq_ack = 2'b01; step(); irq_ack = '0;
      n_tests++; if (irq_pending !== 2'b10) begin n_fail++; $display("FAIL ack_other_rise got=%b exp=10", irq_pending); end
      btn_raw[0] = 1'b0;
      t = 0; while (btn_level[0] !== 1'b0 && t < 20) begin step(); t++; end
      n_tests++; if (btn_level[0] !== 1'b0) begin n_fail++; $display("FAIL wait_level0_low got=%b exp=0", btn_level[0]); end
      btn_raw[0] = 1'b1;
      t = 0; while (btn_level[0] !== 1'b1 && t < 20) begin step(); t++; end
      n_tests++; if (btn_level[0] !== 1'b1) begin n_fail++; $display("FAIL wait_level0_high got=%b exp=1", btn_level[0]); end
      irq_ack = 2'b01; step(); irq_ack = '0;
      n_tests++; if (irq_pending !== 2'b11) begin n_fail++; $display("FAIL ack_same_rise got=%b exp=11", irq_pending); end
   endtask

   task automatic test_mask();
      irq_mask = 2'b00; #1;
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_off_irq got=%b exp=0", irq); end
      irq_mask = 2'b10; #1;
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_on_irq got=%b exp=1", irq); end
      irq_ack = 2'b11; step(); irq_ack = '0;
      n_tests++; if (irq_pending !== 2'b00) begin n_fail++; $display("FAIL ack_clear got=%b exp=00", irq_pending); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ack_clear_irq got=%b exp=0", irq); end
   endtask

   task automatic test_display_page(input logic pg, input logic [3:0][7:0] exp_seg);
      logic [3:0][3:0] exp_an;
      logic [3:0]      prev;
      logic            found;
      exp_an    = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
      disp_data = 32'h1234ABCD; disp_page = pg; disp_en = 1'b1;
      prev = an; found = 1'b0;
      for (int t = 0; t < 30 && !found; t++) begin
         step();
         if (an === 4'b1110 && prev !== 4'b1110) found = 1'b1;
         else prev = an;
      end
      n_tests++; if (!found) begin n_fail++; $display("FAIL disp_sync page=%0d got=%b exp=1110", pg, an); end
      for (int j = 0; j < 12; j++) begin
         if (j > 0) step();
         n_tests++; if (an !== exp_an[j/3]) begin n_fail++; $display("FAIL disp_an page=%0d cyc=%0d got=%b exp=%b", pg, j, an, exp_an[j/3]); end
         n_tests++; if (seg !== exp_seg[j/3]) begin n_fail++; $display("FAIL disp_seg page=%0d cyc=%0d got=%h exp=%h", pg, j, seg, exp_seg[j/3]); end
      end
   endtask

`ifdef IO_PANEL_ZERO_BLANK_EN
   task automatic test_zero_blank();
      int n_on;
      disp_data = 32'h00000005; disp_page = 1'b0; disp_en = 1'b1;
      repeat (2) step();
      n_on = 0;
      for (int j = 0; j < 12; j++) begin
         step();
         if (an === 4'b1110) begin
            n_on++;
            n_tests++; if (seg !== 8'h92) begin n_fail++; $display("FAIL zb_seg cyc=%0d got=%h exp=92", j, seg); end
         end else begin
            n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL zb_an cyc=%0d got=%b exp=1111", j, an); end
         end
      end
      n_tests++; if (n_on != 3) begin n_fail++; $display("FAIL zb_slot0_count got=%0d exp=3", n_on); end
   endtask
`endif

   task automatic test_disp_en();
      disp_en = 1'b1; step();
      disp_en = 1'b0; step();
      n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL dis_an got=%b exp=1111", an); end
      n_tests++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL dis_seg got=%h exp=ff", seg); end
      disp_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int t;
      btn_raw = 2'b00;
      t = 0; while (btn_level !== 2'b00 && t < 20) begin step(); t++; end
      irq_ack = 2'b11; step(); irq_ack = '0;
      btn_raw = 2'b11; irq_mask = 2'b11; disp_en = 1'b1;
      t = 0; while (irq_pending !== 2'b11 && t < 20) begin step(); t++; end
      n_tests++; if (irq_pending !== 2'b11) begin n_fail++; $display("FAIL mid_pre_pending got=%b exp=11", irq_pending); end
      rst = 1'b1; step(); rst = 1'b0;
      n_tests++; if (irq_pending !== 2'b00) begin n_fail++; $display("FAIL mid_pending got=%b exp=00", irq_pending); end
      n_tests++; if (btn_level !== 2'b00) begin n_fail++; $display("FAIL mid_level got=%b exp=00", btn_level); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq got=%b exp=0", irq); end
      n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL mid_an got=%b exp=1111", an); end
      n_tests++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL mid_seg got=%h exp=ff", seg); end
      step();
      n_tests++; if (an !== 4'b1110) begin n_fail++; $display("FAIL mid_first_slot got=%b exp=1110", an); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < NB; i++) if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
         irq_ack = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
         if ($urandom_range(0, 9) == 0) irq_mask = NB'($urandom);
         if ($urandom_range(0, 39) == 0) disp_data = $urandom;
         if ($urandom_range(0, 29) == 0) disp_data = disp_data & 32'h00F000F0;
         if ($urandom_range(0, 29) == 0) disp_page = ~disp_page;
         if ($urandom_range(0, 19) == 0) disp_en = ~disp_en;
         step();
         n_tests++; if (btn_level !== m_lvl) begin n_fail++; $display("FAIL rnd_level k=%0d got=%b exp=%b", k, btn_level, m_lvl); end
         n_tests++; if (irq_pending !== m_pend) begin n_fail++; $display("FAIL rnd_pending k=%0d got=%b exp=%b", k, irq_pending, m_pend); end
         n_tests++; if (irq !== |(m_pend & irq_mask)) begin n_fail++; $display("FAIL rnd_irq k=%0d got=%b exp=%b", k, irq, |(m_pend & irq_mask)); end
         n_tests++; if (an !== m_an) begin n_fail++; $display("FAIL rnd_an k=%0d got=%b exp=%b", k, an, m_an); end
         n_tests++; if (seg !== m_seg) begin n_fail++; $display("FAIL rnd_seg k=%0d got=%h exp=%h", k, seg, m_seg); end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_ack_collision();
      test_mask();
      test_display_page(1'b0, {8'h88, 8'h83, 8'hC6, 8'hA1});
      test_display_page(1'b1, {8'hF9, 8'hA4, 8'hB0, 8'h19});
`ifdef IO_PANEL_ZERO_BLANK_EN
      test_zero_blank();
`endif
      test_disp_en();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
